// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that consumes WIDTH-bit operands
// DIGIT bits per clock, linking slices through a carry register.
//
// Ports:
//   i_w_clk    clock, all state updates on the rising edge
//   i_w_reset  synchronous active-high reset
//   i_w_start  request, sampled only while idle
//   i_w_a      operand A, latched on an accepted start
//   i_w_b      operand B, latched on an accepted start
//   i_w_cin    carry-in (add) / borrow-in (sub), latched on an accepted start
//   i_w_sub    0: A+B+cin, 1: A-B-cin, latched on an accepted start
//   o_w_busy   high while an operation is running or completing
//   o_w_done   one-cycle pulse, result valid
//   o_w_s      result, held until the next completion or reset
//   o_w_cout   carry-out; in subtract mode 1 means no borrow
//   o_w_ovf    signed overflow, present only when SERIAL_ADDER_OVERFLOW_EN
//              is defined
//
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN

module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_cin,
  input  logic             i_w_sub,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_s,
  output logic             o_w_cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             o_w_ovf
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = DIGIT + 1;

  // Slices must tile the operand exactly.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             busy_d;
  logic             done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_d;
`endif

  // Slice datapath: DIGIT-bit add with one extra bit for the carry.
  logic [SW-1:0]          slice_sum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   last_slice;
  logic                   msb_cin;

  assign slice_sum  = SW'(a_q[DIGIT-1:0]) + SW'(b_q[DIGIT-1:0]) + SW'(carry_q);
  // New slice enters from the MSB side; oldest slice falls off the bottom.
  assign res_cat    = {slice_sum[DIGIT-1:0], r_q};
  assign res_shift  = WIDTH'(res_cat >> DIGIT);
  assign last_slice = (cnt_q == CW'(N - 1));
  // Carry into the operand MSB recovered from the top bit of the last slice.
  assign msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = o_w_s;
    cout_d  = o_w_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = o_w_ovf;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_w_start) begin
          // Subtraction is A + ~B + ~borrow.
          a_d     = i_w_a;
          b_d     = i_w_sub ? ~i_w_b : i_w_b;
          carry_d = i_w_sub ? ~i_w_cin : i_w_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        r_d     = res_shift;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          cnt_d   = '0;
          s_d     = res_shift;
          cout_d  = slice_sum[DIGIT];
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = msb_cin ^ slice_sum[DIGIT];
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifndef SERIAL_ADDER_OVERFLOW_EN
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif

  // State and output registers.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      o_w_busy <= 1'b0;
      o_w_done <= 1'b0;
      o_w_s    <= '0;
      o_w_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      o_w_ovf  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      o_w_busy <= busy_d;
      o_w_done <= done_d;
      o_w_s    <= s_d;
      o_w_cout <= cout_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      o_w_ovf  <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations run in parallel against an
// arithmetic reference model, plus literal expectations for known cases.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit fin [4];

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int unsigned W = (g < 2) ? 8 : 4;
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : 2;
    localparam int N    = W / D;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         rst, start, cin, sub, busy, done, cout;
    logic [W-1:0] a, b, s;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .i_w_clk   (clk),
      .i_w_reset (rst),
      .i_w_start (start),
      .i_w_a     (a),
      .i_w_b     (b),
      .i_w_cin   (cin),
      .i_w_sub   (sub),
      .o_w_busy  (busy),
      .o_w_done  (done),
      .o_w_s     (s),
      .o_w_cout  (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ,
      .o_w_ovf   (ovf)
`endif
    );

    // Reference model: ph counts cycles since acceptance (0 = idle).
    int ph = 0;
    int e_s = 0, e_c = 0, e_v = 0;
    int p_s = 0, p_c = 0, p_v = 0;
    int ua, ub, sa, sb, r, sr;
    bit chk_en = 1'b0;
    int last_s, last_c, last_v, last_lat;

    always @(posedge clk) begin
      if (rst) begin
        ph = 0; e_s = 0; e_c = 0; e_v = 0;
      end else if (ph == 0) begin
        if (start) begin
          ua  = int'(a);
          ub  = int'(b);
          sa  = (ua >= HALF) ? ua - MOD : ua;
          sb  = (ub >= HALF) ? ub - MOD : ub;
          r   = sub ? ua - ub - int'(cin) : ua + ub + int'(cin);
          sr  = sub ? sa - sb - int'(cin) : sa + sb + int'(cin);
          p_s = r & (MOD - 1);
          p_c = sub ? int'(r >= 0) : int'(r >= MOD);
          p_v = int'((sr < -HALF) || (sr >= HALF));
          ph  = 1;
        end
      end else if (ph == N + 1) begin
        ph = 0;
      end else begin
        ph++;
        if (ph == N + 1) begin
          e_s = p_s; e_c = p_c; e_v = p_v;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check("busy", g, 32'(busy), 32'(ph != 0));
        check("done", g, 32'(done), 32'(ph == N + 1));
        check("s",    g, 32'(s),    32'(e_s));
        check("cout", g, 32'(cout), 32'(e_c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf",  g, 32'(ovf),  32'(e_v));
`endif
      end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input logic ts);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      a = ta; b = tbv; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      // Occasional start while busy, and operands scrambled after acceptance.
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      for (int k = 0; k < N + 4; k++) begin
        if (done === 1'b1) begin
          seen = 1'b1;
          last_lat = k + 1;
          break;
        end
        @(negedge clk);
        start = 1'b0;
      end
      if (!seen) begin
        check("done_timeout", g, 32'(0), 32'(1));
      end else begin
        last_s = int'(s);
        last_c = int'(cout);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        last_v = int'(ovf);
`endif
        // Start during the done cycle must be ignored.
        start = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    initial begin : stim
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", g, 32'(busy), 32'(0));
      check("rst_done", g, 32'(done), 32'(0));
      check("rst_s",    g, 32'(s),    32'(0));
      check("rst_cout", g, 32'(cout), 32'(0));
      rst = 1'b0;
      chk_en = 1'b1;

      case (g)
        0: begin
          do_op(W'(8'hFF), W'(8'h01), 1'b0, 1'b0);
          check("lit_ff_s",   g, 32'(last_s),   32'h00);
          check("lit_ff_c",   g, 32'(last_c),   32'h1);
          check("lit_ff_lat", g, 32'(last_lat), 32'd9);
          do_op(W'(8'h05), W'(8'h07), 1'b0, 1'b1);
          check("lit_sub_s",  g, 32'(last_s),   32'hFE);
          check("lit_sub_c",  g, 32'(last_c),   32'h0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
          do_op(W'(8'h7F), W'(8'h01), 1'b0, 1'b0);
          check("lit_ovf1_s", g, 32'(last_s), 32'h80);
          check("lit_ovf1_v", g, 32'(last_v), 32'h1);
          do_op(W'(8'h80), W'(8'h01), 1'b0, 1'b1);
          check("lit_ovf2_s", g, 32'(last_s), 32'h7F);
          check("lit_ovf2_v", g, 32'(last_v), 32'h1);
          do_op(W'(8'h10), W'(8'h01), 1'b0, 1'b0);
          check("lit_ovf3_s", g, 32'(last_s), 32'h11);
          check("lit_ovf3_v", g, 32'(last_v), 32'h0);
`endif
          // Reset during the third RUN cycle abandons the operation.
          @(negedge clk);
          a = W'(8'h55); b = W'(8'h0F); cin = 1'b0; sub = 1'b0; start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (2) @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("midrst_busy", g, 32'(busy), 32'(0));
          check("midrst_s",    g, 32'(s),    32'(0));
          repeat (N + 2) begin
            @(negedge clk);
            check("midrst_nodone", g, 32'(done), 32'(0));
          end
          // Start held high throughout a run: no effect on the result.
          @(negedge clk);
          a = W'(8'h12); b = W'(8'h34); cin = 1'b0; sub = 1'b0; start = 1'b1;
          repeat (N) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
          end
          @(negedge clk);
          check("hold_done", g, 32'(done), 32'(1));
          check("hold_s",    g, 32'(s),    32'h46);
          @(negedge clk);
          start = 1'b0;
          check("hold_idle", g, 32'(busy), 32'(0));
          check("hold_s2",   g, 32'(s),    32'h46);
          for (int i = 0; i < 150; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        1: begin
          do_op(W'(8'h3C), W'(8'h45), 1'b1, 1'b0);
          check("lit_d4_s",   g, 32'(last_s),   32'h82);
          check("lit_d4_c",   g, 32'(last_c),   32'h0);
          check("lit_d4_lat", g, 32'(last_lat), 32'd3);
          for (int i = 0; i < 150; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        default: begin
          for (int x = 0; x < MOD; x++)
            for (int y = 0; y < MOD; y++)
              for (int c = 0; c < 2; c++)
                for (int sb_i = 0; sb_i < 2; sb_i++)
                  do_op(W'(x), W'(y), 1'(c), 1'(sb_i));
        end
      endcase
      repeat (2) @(negedge clk);
      fin[g] = 1'b1;
    end
  end

  initial begin : main
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (fin[0] && fin[1] && fin[2] && fin[3]) break;
    end
    check("all_finished", -1, 32'(fin[0] & fin[1] & fin[2] & fin[3]), 32'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
